// File: rtl/bp_ecg_scheduler.sv
// BP-mode entropy encoder sequencer: 3 components x 4 ECGs per block.
// Carries sign bits within a component, stuffs underflow on the final ECG.
module bp_ecg_scheduler #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_blk_start,
    input  logic [2:0]                i_blk_comp_skip,
    input  logic [1:0]                i_blk_sub_sample,
    input  logic [7:0]                i_blk_min_bits,
    output logic                      o_blk_busy,
    output logic                      o_blk_done,
    output logic                      o_blk_err,
    output logic [11:0]               o_blk_bits,
    input  logic                      i_grp_valid,
    output logic                      o_grp_ready,
    input  logic [4*DATA_WIDTH-1:0]   i_grp_data,
    output logic [DATA_WIDTH-1:0]     o_enc_sample_1,
    output logic [DATA_WIDTH-1:0]     o_enc_sample_2,
    output logic [DATA_WIDTH-1:0]     o_enc_sample_3,
    output logic [DATA_WIDTH-1:0]     o_enc_sample_4,
    output logic [1:0]                o_enc_ecgidx,
    output logic [1:0]                o_enc_component_idx,
    output logic                      o_enc_component_skip,
    output logic [1:0]                o_enc_sub_sample_info,
    output logic                      o_enc_underflow_prev,
    output logic [7:0]                o_enc_stuffing_bits,
    output logic [11:0]               o_enc_sign_bits_in,
    output logic [3:0]                o_enc_sign_size_in,
    input  logic [49:0]               i_enc_encoded_ECG,
    input  logic [6:0]                i_enc_size,
    input  logic                      i_enc_valid_op,
    input  logic [3:0]                i_enc_sign_bits_out,
    input  logic [2:0]                i_enc_sign_size_out,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [49:0]               o_out_ecg,
    output logic [6:0]                o_out_size,
    output logic [1:0]                o_out_comp,
    output logic [1:0]                o_out_ecgidx
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_comp;
    logic [1:0]  r_ecg;
    logic [2:0]  r_skip_mask;
    logic [1:0]  r_sub;
    logic [7:0]  r_min_bits;
    logic [11:0] r_carry;
    logic [3:0]  r_carry_sz;

    logic [3:0]  w_skip4;
    logic        w_cur_skip;
    logic [1:0]  w_nxt_comp;
    logic        w_nxt_skip;
    logic        w_last;
    logic        w_uflow;
    logic [2:0]  w_sgn_sz;
    logic [3:0]  w_sgn_mask;
    logic [11:0] w_sgn_bits;

    always_comb begin
        w_skip4    = {1'b0, r_skip_mask};
        w_cur_skip = w_skip4[r_comp];
        w_nxt_comp = (r_ecg == 2'd3) ? r_comp + 2'd1 : r_comp;
        w_nxt_skip = w_skip4[w_nxt_comp];
        w_last     = (r_comp == 2'd2) && (r_ecg == 2'd3);
        w_uflow    = w_last && (o_blk_bits < {4'd0, r_min_bits});
        // the encoder never reports more than 4 sign bits per ECG
        w_sgn_sz   = (i_enc_sign_size_out > 3'd4) ? 3'd4 : i_enc_sign_size_out;
        w_sgn_mask = 4'h0;
        unique case (w_sgn_sz)
            3'd0:    w_sgn_mask = 4'h0;
            3'd1:    w_sgn_mask = 4'h1;
            3'd2:    w_sgn_mask = 4'h3;
            3'd3:    w_sgn_mask = 4'h7;
            default: w_sgn_mask = 4'hF;
        endcase
        w_sgn_bits = {8'd0, i_enc_sign_bits_out & w_sgn_mask};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state               <= ST_IDLE;
            r_comp                <= '0;
            r_ecg                 <= '0;
            r_skip_mask           <= '0;
            r_sub                 <= '0;
            r_min_bits            <= '0;
            r_carry               <= '0;
            r_carry_sz            <= '0;
            o_blk_busy            <= 1'b0;
            o_blk_done            <= 1'b0;
            o_blk_err             <= 1'b0;
            o_blk_bits            <= '0;
            o_grp_ready           <= 1'b0;
            o_enc_sample_1        <= '0;
            o_enc_sample_2        <= '0;
            o_enc_sample_3        <= '0;
            o_enc_sample_4        <= '0;
            o_enc_ecgidx          <= '0;
            o_enc_component_idx   <= '0;
            o_enc_component_skip  <= 1'b0;
            o_enc_sub_sample_info <= '0;
            o_enc_underflow_prev  <= 1'b0;
            o_enc_stuffing_bits   <= '0;
            o_enc_sign_bits_in    <= '0;
            o_enc_sign_size_in    <= '0;
            o_out_valid           <= 1'b0;
            o_out_ecg             <= '0;
            o_out_size            <= '0;
            o_out_comp            <= '0;
            o_out_ecgidx          <= '0;
        end else begin
            o_blk_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_blk_start) begin
                        r_skip_mask <= i_blk_comp_skip;
                        r_sub       <= i_blk_sub_sample;
                        r_min_bits  <= i_blk_min_bits;
                        r_comp      <= '0;
                        r_ecg       <= '0;
                        r_carry     <= '0;
                        r_carry_sz  <= '0;
                        o_blk_err   <= 1'b0;
                        o_blk_bits  <= '0;
                        o_blk_busy  <= 1'b1;
                        o_grp_ready <= !i_blk_comp_skip[0];
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_cur_skip || (o_grp_ready && i_grp_valid)) begin
                        o_grp_ready           <= 1'b0;
                        o_enc_sample_1        <= w_cur_skip ? '0 : i_grp_data[DW-1:0];
                        o_enc_sample_2        <= w_cur_skip ? '0 : i_grp_data[2*DW-1:DW];
                        o_enc_sample_3        <= w_cur_skip ? '0 : i_grp_data[3*DW-1:2*DW];
                        o_enc_sample_4        <= w_cur_skip ? '0 : i_grp_data[4*DW-1:3*DW];
                        o_enc_ecgidx          <= r_ecg;
                        o_enc_component_idx   <= r_comp;
                        o_enc_component_skip  <= w_cur_skip;
                        o_enc_sub_sample_info <= r_sub;
                        o_enc_underflow_prev  <= w_uflow;
                        o_enc_stuffing_bits   <= w_uflow ? r_min_bits - o_blk_bits[7:0] : '0;
                        o_enc_sign_bits_in    <= (r_ecg == 2'd3) ? r_carry : '0;
                        o_enc_sign_size_in    <= (r_ecg == 2'd3) ? r_carry_sz : '0;
                        r_state               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    o_out_ecg    <= i_enc_encoded_ECG;
                    o_out_size   <= i_enc_size;
                    o_out_comp   <= r_comp;
                    o_out_ecgidx <= r_ecg;
                    o_blk_bits   <= o_blk_bits + {5'd0, i_enc_size};
                    if (!i_enc_valid_op) begin
                        o_blk_err <= 1'b1;
                    end
                    if (r_ecg == 2'd3) begin
                        r_carry    <= '0;
                        r_carry_sz <= '0;
                    end else begin
                        r_carry    <= (r_carry << w_sgn_sz) | w_sgn_bits;
                        r_carry_sz <= r_carry_sz + {1'b0, w_sgn_sz};
                    end
                    o_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        if (w_last) begin
                            o_blk_busy <= 1'b0;
                            o_blk_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_ecg       <= r_ecg + 2'd1;
                            r_comp      <= w_nxt_comp;
                            o_grp_ready <= !w_nxt_skip;
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_ecg_scheduler.sv
// Directed bench for bp_ecg_scheduler with a registered 1-cycle encoder model.
// Covers ordering, skip, stall, underflow, sign carry, error and reset.
`timescale 1ns/1ps
module tb_bp_ecg_scheduler;
    localparam int DW = 10;
    localparam logic [39:0] GRP = {10'd4, 10'h3FD, 10'd2, 10'd1};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          blk_start = 1'b0;
    logic [2:0]    blk_comp_skip = '0;
    logic [1:0]    blk_sub_sample = '0;
    logic [7:0]    blk_min_bits = '0;
    logic          blk_busy, blk_done, blk_err;
    logic [11:0]   blk_bits;
    logic          grp_valid = 1'b1;
    logic          grp_ready;
    logic [4*DW-1:0] grp_data = GRP;
    logic [DW-1:0] s1, s2, s3, s4;
    logic [1:0]    enc_ecgidx, enc_comp, enc_sub;
    logic          enc_skip, enc_uf;
    logic [7:0]    enc_stuff;
    logic [11:0]   enc_sbits_in;
    logic [3:0]    enc_ssz_in;
    logic [49:0]   enc_ecg = '0;
    logic [6:0]    enc_size = '0;
    logic          enc_vop = 1'b0;
    logic [3:0]    enc_sbits_out = '0;
    logic [2:0]    enc_ssz_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [49:0]   out_ecg;
    logic [6:0]    out_size;
    logic [1:0]    out_comp, out_ecgidx;

    always #5 clk = ~clk;

    bp_ecg_scheduler #(.DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_blk_start(blk_start),
        .i_blk_comp_skip(blk_comp_skip), .i_blk_sub_sample(blk_sub_sample),
        .i_blk_min_bits(blk_min_bits), .o_blk_busy(blk_busy),
        .o_blk_done(blk_done), .o_blk_err(blk_err), .o_blk_bits(blk_bits),
        .i_grp_valid(grp_valid), .o_grp_ready(grp_ready), .i_grp_data(grp_data),
        .o_enc_sample_1(s1), .o_enc_sample_2(s2),
        .o_enc_sample_3(s3), .o_enc_sample_4(s4),
        .o_enc_ecgidx(enc_ecgidx), .o_enc_component_idx(enc_comp),
        .o_enc_component_skip(enc_skip), .o_enc_sub_sample_info(enc_sub),
        .o_enc_underflow_prev(enc_uf), .o_enc_stuffing_bits(enc_stuff),
        .o_enc_sign_bits_in(enc_sbits_in), .o_enc_sign_size_in(enc_ssz_in),
        .i_enc_encoded_ECG(enc_ecg), .i_enc_size(enc_size),
        .i_enc_valid_op(enc_vop), .i_enc_sign_bits_out(enc_sbits_out),
        .i_enc_sign_size_out(enc_ssz_out), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_ecg(out_ecg), .o_out_size(out_size),
        .o_out_comp(out_comp), .o_out_ecgidx(out_ecgidx)
    );

    logic [6:0] t_size[12];
    logic       t_vop[12];
    logic [3:0] t_sbits[12];
    logic [2:0] t_ssz[12];
    int         m_k;

    always @(posedge clk) begin
        m_k = int'(enc_comp) * 4 + int'(enc_ecgidx);
        if (m_k > 11) m_k = 11;
        enc_ecg       <= {6'd0, enc_comp, enc_ecgidx, s4, s3, s2, s1};
        enc_size      <= t_size[m_k];
        enc_vop       <= t_vop[m_k];
        enc_sbits_out <= t_sbits[m_k];
        enc_ssz_out   <= t_ssz[m_k];
    end

    int         n_out = 0;
    int         n_grp = 0;
    logic [1:0] l_comp[128], l_eidx[128], l_sub[128];
    logic [6:0] l_size[128];
    logic [49:0] l_ecg[128];
    logic       l_skip[128], l_uf[128];
    logic [7:0] l_stuff[128];
    logic [3:0] l_ssz[128];
    logic [11:0] l_sbits[128];

    always @(negedge clk) begin
        if (grp_ready && grp_valid) n_grp = n_grp + 1;
        if (out_valid && out_ready) begin
            l_comp[n_out % 128]  = out_comp;
            l_eidx[n_out % 128]  = out_ecgidx;
            l_size[n_out % 128]  = out_size;
            l_ecg[n_out % 128]   = out_ecg;
            l_skip[n_out % 128]  = enc_skip;
            l_sub[n_out % 128]   = enc_sub;
            l_uf[n_out % 128]    = enc_uf;
            l_stuff[n_out % 128] = enc_stuff;
            l_ssz[n_out % 128]   = enc_ssz_in;
            l_sbits[n_out % 128] = enc_sbits_in;
            n_out = n_out + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int base_out, base_grp, cyc;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [49:0] exp_ecg(input int k, input logic sk);
        logic [1:0] c, e;
        c = 2'(k / 4);
        e = 2'(k % 4);
        return {6'd0, c, e, sk ? 40'd0 : GRP};
    endfunction

    task automatic set_tbl(input logic [6:0] sz);
        for (int i = 0; i < 12; i++) begin
            t_size[i]  = sz;
            t_vop[i]   = 1'b1;
            t_sbits[i] = 4'd0;
            t_ssz[i]   = 3'd0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({blk_busy, blk_done, blk_err, blk_bits,
                                  grp_ready, out_valid}), 64'd0);
        check({tag, "_enc"}, 64'({s4, s3, s2, s1, enc_ecgidx, enc_comp,
                                  enc_skip, enc_sub, enc_uf, enc_stuff}), 64'd0);
        check({tag, "_sgn"}, 64'({enc_sbits_in, enc_ssz_in}), 64'd0);
        check({tag, "_out"}, 64'({out_comp, out_ecgidx, out_size, out_ecg}), 64'd0);
    endtask

    task automatic run_block(input logic [2:0] skip, input logic [1:0] sub,
                             input logic [7:0] minb, input bit stall,
                             output int ncyc);
        bit stalled;
        base_out = n_out;
        base_grp = n_grp;
        @(posedge clk); #2;
        blk_start      = 1'b1;
        blk_comp_skip  = skip;
        blk_sub_sample = sub;
        blk_min_bits   = minb;
        out_ready      = !stall;
        @(posedge clk); #2;
        blk_start      = 1'b0;
        blk_comp_skip  = 3'd0;
        blk_sub_sample = 2'd0;
        blk_min_bits   = 8'd0;
        ncyc = 1;
        stalled = 1'b0;
        check("busy", 64'(blk_busy), 64'd1);
        while (ncyc < 600) begin
            @(negedge clk);
            if (blk_done) break;
            if (stall && !stalled && out_valid) begin
                stalled = 1'b1;
                repeat (5) begin
                    @(posedge clk); ncyc++;
                    @(negedge clk);
                    check("stall_out", 64'({out_valid, out_comp, out_ecgidx,
                                            out_size, out_ecg}),
                          64'({1'b1, 2'd0, 2'd0, t_size[0], exp_ecg(0, 1'b0)}));
                    check("stall_ctl", 64'({grp_ready, enc_ecgidx, enc_comp}), 64'd0);
                end
                @(posedge clk); ncyc++;
                #2 out_ready = 1'b1;
                continue;
            end
            @(posedge clk); ncyc++;
        end
        check("done_seen", 64'(blk_done), 64'd1);
    endtask

    logic [63:0] acc;

    initial begin
        set_tbl(7'd10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #2 rst_n = 1'b1;

        // 1: full block, no skip
        run_block(3'b000, 2'd1, 8'd0, 1'b0, cyc);
        check("t1_cycles", 64'(cyc), 64'd49);
        check("t1_bits", 64'(blk_bits), 64'd120);
        check("t1_err", 64'(blk_err), 64'd0);
        check("t1_grp", 64'(n_grp - base_grp), 64'd12);
        check("t1_nout", 64'(n_out - base_out), 64'd12);
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            check("t1_order", 64'({l_comp[(base_out + k) % 128], l_eidx[(base_out + k) % 128],
                                   l_size[(base_out + k) % 128], l_ecg[(base_out + k) % 128]}),
                  64'({2'(k / 4), 2'(k % 4), 7'd10, exp_ecg(k, 1'b0)}));
            acc = acc | 64'({l_uf[(base_out + k) % 128], l_stuff[(base_out + k) % 128],
                             l_ssz[(base_out + k) % 128], l_sbits[(base_out + k) % 128],
                             l_skip[(base_out + k) % 128], l_sub[(base_out + k) % 128] ^ 2'd1});
        end
        check("t1_side", acc, 64'd0);

        // 2: component 1 skipped
        run_block(3'b010, 2'd0, 8'd0, 1'b0, cyc);
        check("t2_grp", 64'(n_grp - base_grp), 64'd8);
        check("t2_nout", 64'(n_out - base_out), 64'd12);
        check("t2_bits", 64'(blk_bits), 64'd120);
        for (int k = 0; k < 12; k++) begin
            check("t2_out", 64'({l_skip[(base_out + k) % 128], l_ecg[(base_out + k) % 128]}),
                  64'({(k / 4) == 1, exp_ecg(k, (k / 4) == 1)}));
        end

        // 3: downstream stall on the first result
        run_block(3'b000, 2'd0, 8'd0, 1'b1, cyc);
        check("t3_nout", 64'(n_out - base_out), 64'd12);
        check("t3_bits", 64'(blk_bits), 64'd120);
        check("t3_first", 64'({l_comp[base_out % 128], l_eidx[base_out % 128]}), 64'd0);
        check("t3_last", 64'({l_comp[(base_out + 11) % 128], l_eidx[(base_out + 11) % 128]}),
              64'({2'd2, 2'd3}));

        // 4: underflow stuffing on the final issue
        set_tbl(7'd5);
        t_size[10] = 7'd10;
        t_size[11] = 7'd7;
        run_block(3'b000, 2'd0, 8'd200, 1'b0, cyc);
        check("t4_bits", 64'(blk_bits), 64'd67);
        check("t4_last", 64'({l_uf[(base_out + 11) % 128], l_stuff[(base_out + 11) % 128]}),
              64'({1'b1, 8'd140}));
        acc = '0;
        for (int k = 0; k < 11; k++)
            acc = acc | 64'({l_uf[(base_out + k) % 128], l_stuff[(base_out + k) % 128]});
        check("t4_early", acc, 64'd0);

        // 5: sign-bit carry per component
        set_tbl(7'd10);
        t_sbits[0] = 4'b1110; t_ssz[0] = 3'd2;
        t_sbits[1] = 4'b1011; t_ssz[1] = 3'd3;
        t_sbits[2] = 4'b1101; t_ssz[2] = 3'd4;
        t_sbits[3] = 4'b0111; t_ssz[3] = 3'd3;
        t_sbits[4] = 4'b1111; t_ssz[4] = 3'd1;
        t_sbits[5] = 4'b1010; t_ssz[5] = 3'd0;
        t_sbits[6] = 4'b0110; t_ssz[6] = 3'd4;
        run_block(3'b000, 2'd0, 8'd0, 1'b0, cyc);
        check("t5_c0e2", 64'({l_ssz[(base_out + 2) % 128], l_sbits[(base_out + 2) % 128]}), 64'd0);
        check("t5_c0e3", 64'({l_ssz[(base_out + 3) % 128], l_sbits[(base_out + 3) % 128]}),
              64'({4'd9, 12'h13D}));
        check("t5_c1e3", 64'({l_ssz[(base_out + 7) % 128], l_sbits[(base_out + 7) % 128]}),
              64'({4'd5, 12'h016}));
        check("t5_c2e3", 64'({l_ssz[(base_out + 11) % 128], l_sbits[(base_out + 11) % 128]}), 64'd0);

        // 6: encoder error, then reset mid-block and a clean rerun
        set_tbl(7'd10);
        t_vop[6] = 1'b0;
        run_block(3'b000, 2'd0, 8'd0, 1'b0, cyc);
        check("t6_err", 64'(blk_err), 64'd1);
        set_tbl(7'd10);
        @(posedge clk); #2 blk_start = 1'b1;
        @(posedge clk); #2 blk_start = 1'b0;
        repeat (22) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("t6_rst");
        @(posedge clk); #2 rst_n = 1'b1;
        run_block(3'b000, 2'd0, 8'd0, 1'b0, cyc);
        check("t6_cycles", 64'(cyc), 64'd49);
        check("t6_bits", 64'(blk_bits), 64'd120);
        check("t6_err_clr", 64'(blk_err), 64'd0);
        check("t6_nout", 64'(n_out - base_out), 64'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
